// File: rtl/router_csr_mc_pkg.sv
// Shared definitions for the router CSR bank.
// Holds the register map offsets, the read FSM state type, the address decode
// kind and the byte-strobe merge helper.
package router_csr_mc_pkg;

    // Register map (byte offsets within the 4 KiB window)
    localparam logic [11:0] CFG_BASE = 12'h000;
    localparam logic [11:0] STA_BASE = 12'h100;
    localparam logic [11:0] PEND_OFS = 12'h200;
    localparam logic [11:0] MASK_OFS = 12'h204;
    localparam logic [11:0] SNAP_OFS = 12'h208;

    typedef enum logic {
        IDLE,
        RDATA
    } fsm_e;

    typedef enum logic [2:0] {
        CFG,
        STA,
        PEND,
        MASK,
        SNAP,
        NOOP
    } dec_e;

    // Replace the bytes of old_word whose strobe is set with the matching bytes of wdata.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/router_csr_mc_if.sv
// Host register bus between the bus master and the router CSR bank.
//   write/read   : requests (read held until ready)
//   addr         : byte address
//   wdata/wstrb  : write data and byte enables
//   rdata        : read data, non-zero only while ready & read
//   error        : access error, valid with ready
//   ready        : transfer complete
interface router_csr_mc_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) ();

    logic                  write;
    logic                  read;
    logic [AWIDTH-1:0]     addr;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic [DWIDTH-1:0]     rdata;
    logic                  error;
    logic                  ready;

    modport master (
        output write, read, addr, wdata, wstrb,
        input  rdata, error, ready
    );

    modport slave (
        input  write, read, addr, wdata, wstrb,
        output rdata, error, ready
    );

endinterface

// File: rtl/router_csr_sta_chan.sv
// One status channel of the router CSR bank.
// Samples the live status word every cycle unless frozen; while frozen only a
// capture pulse reloads it. chg pulses in the cycle the held word is about to
// change, so the pending bit sets on the same edge that updates the word.
//   i_hclk, i_hreset : clock, asynchronous active-high reset
//   freeze           : hold the sampled word
//   capture          : one-cycle reload request while frozen
//   sta_in           : live status word from the datapath
//   sta              : sampled status word
//   chg              : change-detect set pulse for the pending bit
module router_csr_sta_chan #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              freeze,
    input  logic              capture,
    input  logic [DWIDTH-1:0] sta_in,
    output logic [DWIDTH-1:0] sta,
    output logic              chg
);

    logic [DWIDTH-1:0] sta_q;
    logic              update;

    assign update = !freeze || capture;
    assign chg    = update && (sta_in != sta_q);
    assign sta    = sta_q;

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            sta_q <= '0;
        end else if (update) begin
            sta_q <= sta_in;
        end
    end

endmodule

// File: rtl/router_csr_mc.sv
// Router CSR bank: NUM_CFG read/write config words, NUM_STA sampled status
// words with freeze/capture, change-detect pending bits (W1C), interrupt mask
// and a registered interrupt. Writes complete in the request cycle; reads take
// one wait state.
//   i_hclk, i_hreset : clock, asynchronous active-high reset
//   bus              : host register bus (slave side)
//   o_cfg            : config words, word i at [i*32 +: 32]
//   i_sta            : live status words, word i at [i*32 +: 32]
//   o_irq            : registered |(PEND & MASK)
module router_csr_mc
    import router_csr_mc_pkg::*;
#(
    parameter int unsigned               AWIDTH  = 32,
    parameter int unsigned               DWIDTH  = 32,
    parameter int unsigned               NUM_CFG = 8,
    parameter int unsigned               NUM_STA = 8,
    parameter logic [NUM_CFG*DWIDTH-1:0] CFG_RST = '0
) (
    input  logic                        i_hclk,
    input  logic                        i_hreset,
    router_csr_mc_if.slave              bus,
    output logic [NUM_CFG*DWIDTH-1:0]   o_cfg,
    input  logic [NUM_STA*DWIDTH-1:0]   i_sta,
    output logic                        o_irq
);

    logic [DWIDTH-1:0]  cfg_q [NUM_CFG];
    logic [DWIDTH-1:0]  cfg_d [NUM_CFG];
    logic [NUM_STA-1:0] pend_q, pend_d, pend_clr;
    logic [NUM_STA-1:0] mask_q, mask_d;
    logic [DWIDTH-1:0]  mask_full;
    logic               freeze_q, freeze_d;
    logic               capture;
    logic               irq_q;
    fsm_e               state_q, state_d;
    logic [DWIDTH-1:0]  rdata_q, rd_word;
    logic               rerr_q;
    logic               rd_cap;
    logic               we;
    logic [DWIDTH-1:0]  sta_word [NUM_STA];
    logic [NUM_STA-1:0] sta_chg;
    logic [11:0]        off;
    int unsigned        idx;
    dec_e               kind;

    // Only the low 12 address bits take part in decode.
    logic unused_addr;
    assign unused_addr = ^bus.addr[AWIDTH-1:12];

    // Address decode; misaligned offsets are unmapped.
    always_comb begin
        off  = bus.addr[11:0];
        idx  = 32'(off[7:2]);
        kind = NOOP;
        if (off[1:0] == 2'b00) begin
            if (off[11:8] == CFG_BASE[11:8] && idx < NUM_CFG) begin
                kind = CFG;
            end else if (off[11:8] == STA_BASE[11:8] && idx < NUM_STA) begin
                kind = STA;
            end else if (off == PEND_OFS) begin
                kind = PEND;
            end else if (off == MASK_OFS) begin
                kind = MASK;
            end else if (off == SNAP_OFS) begin
                kind = SNAP;
            end
        end
    end

    // Read wins over a simultaneous write, and nothing is written mid-read.
    assign we = (state_q == IDLE) && bus.write && !bus.read;

    // Read mux, registered on the request edge.
    always_comb begin
        rd_word = '0;
        unique case (kind)
            CFG: begin
                for (int unsigned i = 0; i < NUM_CFG; i++) begin
                    if (idx == i) rd_word = cfg_q[i];
                end
            end
            STA: begin
                for (int unsigned i = 0; i < NUM_STA; i++) begin
                    if (idx == i) rd_word = sta_word[i];
                end
            end
            PEND:    rd_word = 32'(pend_q);
            MASK:    rd_word = 32'(mask_q);
            SNAP:    rd_word = 32'(freeze_q);  // CAPTURE always reads 0
            default: rd_word = '0;
        endcase
    end

    // Register-write next state.
    always_comb begin
        cfg_d     = cfg_q;
        mask_d    = mask_q;
        mask_full = '0;
        freeze_d  = freeze_q;
        capture   = 1'b0;
        pend_clr  = '0;
        if (we) begin
            unique case (kind)
                CFG: begin
                    for (int unsigned i = 0; i < NUM_CFG; i++) begin
                        if (idx == i) cfg_d[i] = apply_strb(cfg_q[i], bus.wdata, bus.wstrb);
                    end
                end
                MASK: begin
                    mask_full = apply_strb(32'(mask_q), bus.wdata, bus.wstrb);
                    mask_d    = mask_full[NUM_STA-1:0];
                end
                PEND: pend_clr = bus.wdata[NUM_STA-1:0];
                SNAP: begin
                    freeze_d = bus.wdata[0];
                    capture  = bus.wdata[1];
                end
                default: ;
            endcase
        end
        // A change event in the clearing cycle keeps the bit set.
        pend_d = (pend_q & ~pend_clr) | sta_chg;
    end

    // Read FSM and bus responses.
    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b1;
        bus.error = 1'b0;
        bus.rdata = '0;
        rd_cap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.read) begin
                    bus.ready = 1'b0;
                    rd_cap    = 1'b1;
                    state_d   = RDATA;
                end else if (bus.write) begin
                    bus.error = (kind == STA) || (kind == NOOP);
                end
            end
            RDATA: begin
                bus.rdata = rdata_q;
                bus.error = rerr_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (rd_cap) begin
            rdata_q <= rd_word;
            rerr_q  <= (kind == NOOP);
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST[i*DWIDTH +: DWIDTH];
            pend_q   <= '0;
            mask_q   <= '0;
            freeze_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            freeze_q <= freeze_d;
            irq_q    <= |(pend_q & mask_q);
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign o_cfg[g*DWIDTH +: DWIDTH] = cfg_q[g];
    end

    for (genvar g = 0; g < NUM_STA; g++) begin : g_sta
        router_csr_sta_chan #(
            .DWIDTH (DWIDTH)
        ) u_chan (
            .i_hclk   (i_hclk),
            .i_hreset (i_hreset),
            .freeze   (freeze_q),
            .capture  (capture),
            .sta_in   (i_sta[g*DWIDTH +: DWIDTH]),
            .sta      (sta_word[g]),
            .chg      (sta_chg[g])
        );
    end

    assign o_irq = irq_q;

endmodule

// File: tb/tb_router_csr_mc.sv
// Self-checking bench for router_csr_mc: directed steps followed by a
// randomized phase, all checked against a register-level reference model.
module tb_router_csr_mc;

    localparam int unsigned NC = 8;
    localparam int unsigned NS = 8;
    localparam logic [NC*32-1:0] CFG_RST = {32'h0, 32'h0, 32'h0, 32'h0,
                                            32'hA5A5_0000, 32'h0, 32'h1111_0000, 32'h0};

    logic            clk = 1'b0;
    logic            hreset;
    logic [NC*32-1:0] o_cfg;
    logic [NS*32-1:0] sta_bus;
    logic            o_irq;
    logic [31:0]     sta_in [NS];

    int errors = 0;
    int checks = 0;

    // Reference model state and next state
    logic [31:0]   cfg_m [NC];
    logic [31:0]   sta_m [NS];
    logic [NS-1:0] pend_m, mask_m;
    logic          freeze_m, irq_m;
    logic [31:0]   n_cfg [NC];
    logic [31:0]   n_sta [NS];
    logic [NS-1:0] n_pend, n_mask;
    logic          n_freeze, n_irq;

    router_csr_mc_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    router_csr_mc #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .NUM_CFG (NC),
        .NUM_STA (NS),
        .CFG_RST (CFG_RST)
    ) dut (
        .i_hclk   (clk),
        .i_hreset (hreset),
        .bus      (bus),
        .o_cfg    (o_cfg),
        .i_sta    (sta_bus),
        .o_irq    (o_irq)
    );

    always #5 clk = ~clk;

    always_comb begin
        sta_bus = '0;
        for (int i = 0; i < NS; i++) sta_bus[i*32 +: 32] = sta_in[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 cfg, 1 sta, 2 pend, 3 mask, 4 snap, 5 unmapped
    function automatic int kind_of(input logic [11:0] o);
        int oi;
        oi = int'(o);
        if (oi % 4 != 0)                         return 5;
        if (oi < 4 * NC)                         return 0;
        if (oi >= 'h100 && oi < 'h100 + 4 * NS)  return 1;
        if (oi == 'h200)                         return 2;
        if (oi == 'h204)                         return 3;
        if (oi == 'h208)                         return 4;
        return 5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] o);
        logic [2:0] w;
        w = o[4:2];
        case (kind_of(o))
            0:       return cfg_m[w];
            1:       return sta_m[w];
            2:       return 32'(pend_m);
            3:       return 32'(mask_m);
            4:       return 32'(freeze_m);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) cfg_m[i] = CFG_RST[i*32 +: 32];
        for (int i = 0; i < NS; i++) sta_m[i] = 32'h0;
        pend_m = '0;
        mask_m = '0;
        freeze_m = 1'b0;
        irq_m = 1'b0;
    endtask

    // Effect of one clock edge given the inputs currently on the bus.
    task automatic model_compute();
        logic          we, cap;
        int            k;
        logic [2:0]    w;
        logic [NS-1:0] set;
        logic [31:0]   tmp;
        we  = bus.write && !bus.read;
        k   = kind_of(bus.addr[11:0]);
        w   = bus.addr[4:2];
        cap = we && (k == 4) && bus.wdata[1];
        set = '0;
        for (int i = 0; i < NS; i++) begin
            n_sta[i] = sta_m[i];
            if (!freeze_m || cap) begin
                if (sta_in[i] !== sta_m[i]) set[i] = 1'b1;
                n_sta[i] = sta_in[i];
            end
        end
        n_irq  = |(pend_m & mask_m);
        n_pend = pend_m | set;
        if (we && k == 2) n_pend = (pend_m & ~bus.wdata[NS-1:0]) | set;
        n_cfg = cfg_m;
        if (we && k == 0) n_cfg[w] = merge(cfg_m[w], bus.wdata, bus.wstrb);
        n_mask = mask_m;
        if (we && k == 3) begin
            tmp    = merge(32'(mask_m), bus.wdata, bus.wstrb);
            n_mask = tmp[NS-1:0];
        end
        n_freeze = freeze_m;
        if (we && k == 4) n_freeze = bus.wdata[0];
    endtask

    task automatic step();
        model_compute();
        @(posedge clk);
        #1;
        cfg_m    = n_cfg;
        sta_m    = n_sta;
        pend_m   = n_pend;
        mask_m   = n_mask;
        freeze_m = n_freeze;
        irq_m    = n_irq;
        check("irq", 32'(o_irq), 32'(irq_m));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        bus.write = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = s;
        #1;
        k = kind_of(a[11:0]);
        check("wr_ready", 32'(bus.ready), 32'h1);
        check("wr_error", 32'(bus.error), 32'((k == 1) || (k == 5)));
        step();
        bus.write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic wr, output logic [31:0] data);
        logic [31:0] exp;
        logic        experr;
        bus.read  = 1'b1;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = $urandom;
        bus.wstrb = 4'($urandom_range(15));
        #1;
        exp    = model_read(a[11:0]);
        experr = (kind_of(a[11:0]) == 5);
        check("rd_wait_ready", 32'(bus.ready), 32'h0);
        check("rd_wait_rdata", bus.rdata, 32'h0);
        step();
        check("rd_ready", 32'(bus.ready), 32'h1);
        check("rd_data", bus.rdata, exp);
        check("rd_error", 32'(bus.error), 32'(experr));
        data = bus.rdata;
        step();
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(5))
            0:       return 32'(4 * $urandom_range(NC - 1));
            1:       return 32'('h100 + 4 * $urandom_range(NS - 1));
            2:       return 32'('h200 + 4 * $urandom_range(3));
            3:       return 32'h200;
            4:       return 32'h208;
            default: return 32'($urandom_range(12'hfff));
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        hreset    = 1'b1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        for (int i = 0; i < NS; i++) sta_in[i] = 32'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        hreset = 1'b0;

        // Reset state
        check("rst_ready", 32'(bus.ready), 32'h1);
        check("rst_error", 32'(bus.error), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        for (int i = 0; i < NC; i++) check("rst_cfg", o_cfg[i*32 +: 32], cfg_m[i]);

        // Reset image readback
        do_read(32'h00C, 1'b0, rd);
        check("cfg3_reset", rd, 32'hA5A5_0000);

        // Byte-strobe write
        do_write(32'h000, 32'hDEAD_BEEF, 4'b0101);
        check("cfg0_out", o_cfg[31:0], 32'h00AD_00EF);
        do_read(32'h000, 1'b0, rd);
        check("cfg0_rd", rd, 32'h00AD_00EF);

        // Change detect, interrupt lag, W1C and set-over-clear
        do_write(32'h204, 32'h1, 4'hF);
        sta_in[0] = 32'h5;
        step();
        check("irq_lag0", 32'(o_irq), 32'h0);
        step();
        check("irq_set", 32'(o_irq), 32'h1);
        do_read(32'h200, 1'b0, rd);
        check("pend_set", rd, 32'h1);
        do_write(32'h200, 32'h1, 4'hF);
        step();
        check("irq_clr", 32'(o_irq), 32'h0);
        do_read(32'h200, 1'b0, rd);
        check("pend_clr", rd, 32'h0);
        sta_in[0] = 32'h6;
        do_write(32'h200, 32'h1, 4'hF);
        do_read(32'h200, 1'b0, rd);
        check("pend_set_wins", rd, 32'h1);

        // Freeze and capture
        do_write(32'h200, 32'hFF, 4'hF);
        sta_in[2] = 32'h7;
        step();
        do_write(32'h200, 32'hFF, 4'hF);
        do_write(32'h208, 32'h1, 4'hF);
        sta_in[2] = 32'h9;
        step();
        step();
        do_read(32'h108, 1'b0, rd);
        check("frozen_sta", rd, 32'h7);
        do_read(32'h200, 1'b0, rd);
        check("frozen_pend", rd, 32'h0);
        do_write(32'h208, 32'h3, 4'hF);
        do_read(32'h108, 1'b0, rd);
        check("capture_sta", rd, 32'h9);
        do_read(32'h200, 1'b0, rd);
        check("capture_pend", rd, 32'h4);
        do_read(32'h208, 1'b0, rd);
        check("snap_rd", rd, 32'h1);
        do_write(32'h208, 32'h0, 4'hF);

        // Error accesses
        do_write(32'h104, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h300, 32'hFFFF_FFFF, 4'hF);
        do_read(32'h104, 1'b0, rd);
        do_read(32'h300, 1'b0, rd);
        check("unmapped_rd", rd, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(3) == 0) sta_in[i] = 32'($urandom_range(3));
            end
            case ($urandom_range(9))
                0, 1, 2:    step();
                3, 4, 5:    do_write(rand_addr(), $urandom, 4'($urandom_range(15)));
                default:    do_read(rand_addr(), 1'($urandom_range(1)), rd);
            endcase
        end

        // Reset in the middle of a read
        do_write(32'h004, 32'h55, 4'hF);
        bus.read = 1'b1;
        bus.addr = 32'h004;
        step();
        hreset   = 1'b1;
        bus.read = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ready", 32'(bus.ready), 32'h1);
        check("mid_rst_error", 32'(bus.error), 32'h0);
        check("mid_rst_rdata", bus.rdata, 32'h0);
        check("mid_rst_irq", 32'(o_irq), 32'h0);
        for (int i = 0; i < NC; i++) check("mid_rst_cfg", o_cfg[i*32 +: 32], CFG_RST[i*32 +: 32]);
        @(posedge clk);
        #1;
        hreset = 1'b0;
        do_read(32'h004, 1'b0, rd);
        check("cfg1_after_rst", rd, 32'h1111_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
